// File: rtl/sample_reader.sv
// Sample playback reader: paces BRAM reads with a DIV-cycle divider and hands samples to the FIR.
// Optional overrun detection is built when SAMPLE_READER_OVERRUN_EN is defined.
module sample_reader #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  parameter  int DIV   = 4,
  localparam int LEN   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_loop,
  output logic             o_rden,
  output logic [LEN-1:0]   o_rdaddr,
  input  logic [WIDTH-1:0] i_bramdata,
  output logic [WIDTH-1:0] o_sample,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overrun
);

  localparam int DW = $clog2(DIV);
  localparam logic [LEN-1:0] LAST_ADDR = LEN'(DEPTH - 1);
  localparam logic [DW-1:0]  DIV_MAX   = DW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    CAPTURE,
    HOLD
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_div;
  logic [LEN-1:0]   r_addr;
  logic             r_rden;
  logic [LEN-1:0]   r_rdaddr;
  logic [WIDTH-1:0] r_sample;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_tick;
  logic             w_handshake;
  logic [LEN-1:0]   w_addrNext;

  assign w_tick      = (r_state != IDLE) && (r_div == DIV_MAX);
  assign w_handshake = (r_state == HOLD) && r_valid && i_ready;
  assign w_addrNext  = (r_addr == LAST_ADDR) ? '0 : r_addr + LEN'(1);

  // Stop overrides every transition; the divider free-runs while busy so ticks keep their cadence.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_addr   <= '0;
      r_rden   <= 1'b0;
      r_rdaddr <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE || w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DW'(1);
      end

      if (i_stop) begin
        r_state <= IDLE;
        r_rden  <= 1'b0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start) begin
              r_addr  <= '0;
              r_div   <= '0;
              r_busy  <= 1'b1;
              r_state <= WAIT;
            end
          end
          WAIT: begin
            if (w_tick) begin
              r_rden   <= 1'b1;
              r_rdaddr <= r_addr;
              r_state  <= READ;
            end
          end
          READ: begin
            r_rden  <= 1'b0;
            r_state <= CAPTURE;
          end
          CAPTURE: begin
            r_sample <= i_bramdata;
            r_valid  <= 1'b1;
            r_state  <= HOLD;
          end
          HOLD: begin
            if (w_handshake) begin
              r_valid <= 1'b0;
              r_addr  <= w_addrNext;
              if (r_addr == LAST_ADDR && !i_loop) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else if (w_tick) begin
                // A tick coinciding with the handshake is consumed immediately rather than lost.
                r_rden   <= 1'b1;
                r_rdaddr <= w_addrNext;
                r_state  <= READ;
              end else begin
                r_state <= WAIT;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            r_rden  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SAMPLE_READER_OVERRUN_EN
  logic r_overrun;

  // Sticky until the next accepted start, so software can see that the FIR fell behind.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overrun <= 1'b0;
    end else if (r_state == IDLE && i_start && !i_stop) begin
      r_overrun <= 1'b0;
    end else if (r_state == HOLD && w_tick && !w_handshake) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_overrun = r_overrun;
`else
  assign o_overrun = 1'b0;
`endif

  assign o_rden   = r_rden;
  assign o_rdaddr = r_rdaddr;
  assign o_sample = r_sample;
  assign o_valid  = r_valid;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule
